// File: rtl/relatorio_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relatorio_serial_tx_pkg
// Description : Shared constants, FSM state encoding and ASCII encoders for
//               the serial weight-report transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package relatorio_serial_tx_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  // Values are exported on db_estado, so they are fixed explicitly.
  typedef enum logic [3:0] {
    ST_INICIAL   = 4'd0,
    ST_CARREGA   = 4'd1,
    ST_TRANSMITE = 4'd2,
    ST_PROXIMO   = 4'd3,
    ST_FINAL     = 4'd4
  } estado_t;

  // A digit value outside 0..9 is reported as '?'.
  function automatic logic [7:0] encode_digit(input logic [7:0] d);
    if (d <= 8'd9) begin
      return ASCII_ZERO + d;
    end
    return ASCII_ERR;
  endfunction

  function automatic logic [7:0] encode_flag(input logic f);
    return f ? (ASCII_ZERO + 8'd1) : ASCII_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_serial_8N1_byte.sv
`default_nettype none
// ============================================================================
// Module      : tx_serial_8N1_byte
// Description : Single-byte 8N1 serial transmitter. o_Tx_Done is high during
//               the last cycle of the stop bit; a request seen in that cycle
//               starts the next start bit with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_serial_8N1_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  tx_state_t           r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [3:0]          r_bit;    // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]          r_shift;
  logic                r_serial;
  logic                r_active;
  logic                w_bit_end;

  assign w_bit_end   = (r_baud == c_BAUD_MAX);
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Done   = (r_state == S_STOP) && w_bit_end;

  // Bit sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_shift  <= 8'd0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud   <= '0;
          r_bit    <= 4'd0;
          r_serial <= 1'b1;
          if (i_Tx_DV) begin
            r_shift  <= i_Tx_Byte;
            r_serial <= 1'b0;
            r_active <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_bit    <= 4'd1;
            r_serial <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_state  <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 4'd8) begin
              r_bit    <= 4'd9;
              r_serial <= 1'b1;
              r_state  <= S_STOP;
            end else begin
              r_bit    <= r_bit + 4'd1;
              r_serial <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            r_bit  <= 4'd0;
            if (i_Tx_DV) begin
              // Back-to-back byte: start bit follows the stop bit directly.
              r_shift  <= i_Tx_Byte;
              r_serial <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/relatorio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : relatorio_serial_tx
// Description : On request, snapshots weight digits and in-range flag and
//               sends the 4-character report tens, units, flag, '#' over an
//               8N1 serial line with no gap between characters.
// Revision    : 1.0 - initial release
// ============================================================================
module relatorio_serial_tx
  import relatorio_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] peso,
  input  logic        dentro,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  estado_t    r_state;
  logic [7:0] r_dezena;
  logic [7:0] r_unidade;
  logic       r_dentro;
  logic [1:0] r_idx;
  logic       r_kick;
  logic       r_pronto;

  logic       w_tx_done;
  logic       w_tx_active;
  logic       w_tx_serial;
  logic       w_load_next;
  logic       w_tx_dv;
  logic [1:0] w_sel;
  logic [7:0] w_tx_byte;

  // Next-byte handoff happens in the stop-bit's last cycle so the next start
  // bit lands on the very edge that ends the previous stop bit.
  always_comb begin
    w_load_next = (r_state == ST_TRANSMITE) && w_tx_done && (r_idx != 2'd3);
    w_sel       = w_load_next ? (r_idx + 2'd1) : r_idx;
    w_tx_dv     = r_kick | w_load_next;
    w_tx_byte   = ASCII_HASH;
    case (w_sel)
      2'd0:    w_tx_byte = encode_digit(r_dezena);
      2'd1:    w_tx_byte = encode_digit(r_unidade);
      2'd2:    w_tx_byte = encode_flag(r_dentro);
      default: w_tx_byte = ASCII_HASH;
    endcase
  end

  // Report FSM; the load step is folded into the request edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_INICIAL;
      r_dezena  <= 8'd0;
      r_unidade <= 8'd0;
      r_dentro  <= 1'b0;
      r_idx     <= 2'd0;
      r_kick    <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_kick   <= 1'b0;
      r_pronto <= 1'b0;
      case (r_state)
        ST_INICIAL: begin
          if (partida) begin
            r_dezena  <= peso[15:8];
            r_unidade <= peso[7:0];
            r_dentro  <= dentro;
            r_idx     <= 2'd0;
            r_kick    <= 1'b1;
            r_state   <= ST_TRANSMITE;
          end
        end
        ST_TRANSMITE: begin
          if (w_tx_done) begin
            if (r_idx == 2'd3) begin
              r_pronto <= 1'b1;
              r_state  <= ST_FINAL;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_PROXIMO;
            end
          end
        end
        ST_PROXIMO: r_state <= ST_TRANSMITE;
        ST_FINAL:   r_state <= ST_INICIAL;
        default:    r_state <= ST_INICIAL;
      endcase
    end
  end

  tx_serial_8N1_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock       (clock),
    .reset       (reset),
    .i_Tx_DV     (w_tx_dv),
    .i_Tx_Byte   (w_tx_byte),
    .o_Tx_Serial (w_tx_serial),
    .o_Tx_Active (w_tx_active),
    .o_Tx_Done   (w_tx_done)
  );

  assign saida_serial = w_tx_serial;
  assign ocupado      = w_tx_active;
  assign pronto       = r_pronto;
  assign db_estado    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_relatorio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_relatorio_serial_tx
// Description : Scoreboard bench for relatorio_serial_tx. Stimulus pushes the
//               expected bytes and their start cycles; a line monitor decodes
//               every 8N1 character and compares against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relatorio_serial_tx;

  localparam int C = 4;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic [15:0] peso = 16'h0000;
  logic        dentro = 1'b0;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   discard = 1'b0;
  exp_t q[$];

  relatorio_serial_tx #(.CLKS_PER_BIT(C)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .peso         (peso),
    .dentro       (dentro),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Decode one character starting at the detected start-bit cycle.
  task automatic mon_byte();
    int         c0;
    logic [9:0] pat;
    bit         ab;
    exp_t       e;
    c0  = cyc;
    pat = '0;
    ab  = 1'b0;
    if (C / 2 == 0) pat[0] = saida_serial;
    for (int off = 1; off <= 9 * C + C / 2; off++) begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        ab = 1'b1;
        break;
      end
      if (off % C == C / 2) pat[off / C] = saida_serial;
    end
    if (ab || discard) return;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_byte: got %02h expected none", pat[8:1]);
    end else begin
      e = q.pop_front();
      chk("byte_frame", 32'(pat), 32'({1'b1, e.b, 1'b0}));
      chk("byte_start_cycle", c0, e.cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && saida_serial === 1'b0) mon_byte();
    end
  end

  // Issue one report and watch ocupado/pronto up to the pronto cycle.
  task automatic send(input string nm, input logic [15:0] p, input logic d,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input bit chg, input logic [15:0] p2, input logic d2,
                      input bit pulse50, input bit pulse_pr);
    int   n;
    int   bad_ocu;
    int   npr;
    int   t_pr;
    logic line_pr;
    @(negedge clock);
    partida = 1'b1;
    peso    = p;
    dentro  = d;
    n       = cyc;
    q.push_back('{b: b0, cyc: n + 2});
    q.push_back('{b: b1, cyc: n + 2 + 10 * C});
    q.push_back('{b: b2, cyc: n + 2 + 20 * C});
    q.push_back('{b: b3, cyc: n + 2 + 30 * C});
    bad_ocu = 0;
    npr     = 0;
    t_pr    = -1;
    line_pr = 1'bx;
    for (int t = 1; t <= 40 * C + 2; t++) begin
      @(negedge clock);
      partida = 1'b0;
      if (t == 1 && chg) begin
        peso   = p2;
        dentro = d2;
      end
      if (pulse50 && t == 50) partida = 1'b1;
      if (pulse_pr && t == 40 * C + 2) partida = 1'b1;
      if (ocupado !== ((t >= 2) && (t < 40 * C + 2))) bad_ocu++;
      if (pronto === 1'b1) begin
        npr++;
        t_pr    = t;
        line_pr = saida_serial;
      end
      if (t == 10) chk({nm, "_estado_tx"}, 32'(db_estado), 32'd2);
      if (t == 40 * C + 2) chk({nm, "_estado_final"}, 32'(db_estado), 32'd4);
    end
    chk({nm, "_ocupado_bad_cycles"}, bad_ocu, 0);
    chk({nm, "_pronto_count"}, npr, 1);
    chk({nm, "_pronto_cycle"}, t_pr, 162);
    chk({nm, "_line_at_pronto"}, 32'(line_pr), 32'd1);
  endtask

  // Count cycles where the outputs leave the idle state.
  task automatic idle_watch(input string nm, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      partida = 1'b0;
      if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    int n;
    // Reset state and long idle with partida low
    repeat (3) @(negedge clock);
    chk("rst_saida", 32'(saida_serial), 32'd1);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    idle_watch("idle_1000", 1000);

    // Basic report and out-of-range digit
    send("t1", 16'h0407, 1'b1, 8'h34, 8'h37, 8'h31, 8'h23, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    send("t2", 16'h0A00, 1'b0, 8'h3F, 8'h30, 8'h30, 8'h23, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    // Inputs change right after the request
    send("t3", 16'h0902, 1'b1, 8'h39, 8'h32, 8'h31, 8'h23, 1'b1, 16'h0305, 1'b0, 1'b0, 1'b0);
    // Requests while busy and in the pronto cycle are dropped
    send("t4a", 16'h0000, 1'b0, 8'h30, 8'h30, 8'h30, 8'h23, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    idle_watch("t4_ignored", 30);
    // Request one cycle after pronto starts the next frame
    send("t4b", 16'h0FFF, 1'b1, 8'h3F, 8'h3F, 8'h31, 8'h23, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    send("t4c", 16'h0801, 1'b0, 8'h38, 8'h31, 8'h30, 8'h23, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Reset during byte 1 aborts the frame
    @(negedge clock);
    partida = 1'b1;
    peso    = 16'h0606;
    dentro  = 1'b1;
    discard = 1'b1;
    n       = cyc;
    for (int t = 1; t <= 10 * C + 2 + 3 * C + 1; t++) begin
      @(negedge clock);
      partida = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    chk("abort_saida", 32'(saida_serial), 32'd1);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_pronto", 32'(pronto), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b1;
    discard = 1'b0;
    idle_watch("abort_no_pronto", 200);
    send("t5", 16'h0203, 1'b1, 8'h32, 8'h33, 8'h31, 8'h23, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
